// File: rtl/core_sequencer.sv
// core_sequencer: loads a program into instruction memory, primes the core reset,
// then gates core commits for run/step/halt, stopping on ECALL/EBREAK or a cycle budget.
module core_sequencer #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_arg,
    output logic              cmd_err,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              core_en,
    input  logic [31:0]       core_instr,
    input  logic [31:0]       core_pc,
    output logic [2:0]        state,
    output logic [1:0]        halt_cause,
    output logic [31:0]       halted_pc,
    output logic [31:0]       cycle_count
);
    typedef enum logic [2:0] {IDLE, LOAD, PRIME, RUN, HALTED} st_t;
    localparam logic [1:0] OP_LOAD = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_HALT = 2'd3;
    localparam logic [1:0] C_USER = 2'd0, C_TRAP = 2'd1, C_LIMIT = 2'd2, C_STEP = 2'd3;
    localparam int PW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;

    st_t st;
    logic [ADDR_W:0] ld_cnt, ld_n;
    logic [PW-1:0] p_cnt;
    logic [31:0] budget;
    logic loaded, trapped, unlimited, is_step, trap, acc;

    assign trap       = core_instr == 32'h0000_0073 || core_instr == 32'h0010_0073;
    assign cmd_ready  = st == IDLE || st == RUN || st == HALTED;
    assign acc        = cmd_valid && cmd_ready;
    assign ld_ready   = st == LOAD;
    assign imem_we    = ld_valid && ld_ready;
    assign imem_addr  = ld_cnt[ADDR_W-1:0];
    assign imem_wdata = ld_data;
    assign core_en    = st == RUN && !trap;
    assign state      = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st           <= IDLE;
            core_reset_n <= 1'b0;
            cmd_err      <= 1'b0;
            halt_cause   <= C_USER;
            halted_pc    <= '0;
            cycle_count  <= '0;
            loaded       <= 1'b0;
            trapped      <= 1'b0;
            unlimited    <= 1'b0;
            is_step      <= 1'b0;
            budget       <= '0;
            ld_cnt       <= '0;
            ld_n         <= '0;
            p_cnt        <= '0;
        end else begin
            cmd_err <= 1'b0;
            case (st)
                IDLE, HALTED: if (acc) begin
                    if (cmd_op == OP_LOAD) begin
                        if (cmd_arg == 32'd0) cmd_err <= 1'b1;
                        else begin
                            ld_n         <= cmd_arg > 32'(DEPTH) ? (ADDR_W+1)'(DEPTH) : cmd_arg[ADDR_W:0];
                            ld_cnt       <= '0;
                            loaded       <= 1'b0;
                            trapped      <= 1'b0;
                            core_reset_n <= 1'b0;
                            st           <= LOAD;
                        end
                    end else if (cmd_op != OP_HALT) begin
                        if (!loaded || trapped || (cmd_op == OP_STEP && cmd_arg == 32'd0)) cmd_err <= 1'b1;
                        else begin
                            budget    <= cmd_arg;
                            unlimited <= cmd_op == OP_RUN && cmd_arg == 32'd0;
                            is_step   <= cmd_op == OP_STEP;
                            st        <= RUN;
                        end
                    end
                end
                LOAD: if (imem_we) begin
                    ld_cnt <= ld_cnt + 1'b1;
                    if (ld_cnt + 1'b1 == ld_n) begin
                        st    <= PRIME;
                        p_cnt <= '0;
                    end
                end
                PRIME: if (p_cnt == PW'(RST_CYCLES - 1)) begin
                    st           <= IDLE;
                    loaded       <= 1'b1;
                    cycle_count  <= '0;
                    core_reset_n <= 1'b1;
                end else p_cnt <= p_cnt + 1'b1;
                RUN: begin
                    if (core_en) begin
                        cycle_count <= cycle_count + 32'd1;
                        if (!unlimited) budget <= budget - 32'd1;
                    end
                    if (acc && cmd_op == OP_LOAD) cmd_err <= 1'b1;
                    // exit priority: trap, then budget expiry, then user halt
                    if (trap) begin
                        st         <= HALTED;
                        halt_cause <= C_TRAP;
                        trapped    <= 1'b1;
                        halted_pc  <= core_pc;
                    end else if (!unlimited && budget == 32'd1) begin
                        st         <= HALTED;
                        halt_cause <= is_step ? C_STEP : C_LIMIT;
                        halted_pc  <= core_pc;
                    end else if (acc && cmd_op == OP_HALT) begin
                        st         <= HALTED;
                        halt_cause <= C_USER;
                        halted_pc  <= core_pc;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: drives load/run/step/halt commands against a tiny core model
// and checks outcomes computed from a straight-line program-execution model.
module tb_core_sequencer;
    localparam logic [1:0] LD = 2'd0, RN = 2'd1, ST = 2'd2, HT = 2'd3;
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_PRIME = 3'd2, S_RUN = 3'd3, S_HALT = 3'd4;
    localparam logic [31:0] NOP = 32'h0000_0013, EBREAK = 32'h0010_0073;

    logic clk = 1'b0, reset = 1'b0;
    logic cmd_valid = 1'b0, ld_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [31:0] cmd_arg = '0, ld_data = '0;
    logic cmd_ready, cmd_err, ld_ready, imem_we, core_reset_n, core_en;
    logic [9:0] imem_addr;
    logic [31:0] imem_wdata, core_instr, halted_pc, cycle_count;
    logic [2:0] state;
    logic [1:0] halt_cause;

    logic [31:0] mem [1024] = '{default: 32'h0000_0013};
    logic [31:0] pc = '0;

    core_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_err(cmd_err),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset_n(core_reset_n), .core_en(core_en),
        .core_instr(core_instr), .core_pc(pc),
        .state(state), .halt_cause(halt_cause), .halted_pc(halted_pc), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // environment: instruction memory and a straight-line core
    always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;
    always @(posedge clk) pc <= !core_reset_n ? 32'd0 : core_en ? pc + 32'd4 : pc;
    assign core_instr = mem[pc[11:2]];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] arg;
        logic        err;
        logic [2:0]  st;
    } vec_t;
    vec_t tv [10];

    int n_tests = 0, n_fail = 0;
    logic [31:0] m_mem [1024];
    logic [31:0] wbuf [1024];
    int unsigned m_pc, m_cc;
    logic m_loaded, m_trapped;
    logic [2:0] m_st;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic is_trap(input logic [31:0] w);
        return w == 32'h0000_0073 || w == EBREAK;
    endfunction

    function automatic logic [31:0] rword();
        logic [31:0] w;
        if ($urandom_range(0, 9) == 0) return $urandom_range(0, 1) != 0 ? EBREAK : 32'h0000_0073;
        w = $urandom;
        w[6:0] = 7'h13;
        return w;
    endfunction

    task automatic do_cmd(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            do_cmd(tv[i].op, tv[i].arg);
            chk($sformatf("vec%0d_err", i), {31'd0, cmd_err}, {31'd0, tv[i].err});
            chk($sformatf("vec%0d_state", i), {29'd0, state}, {29'd0, tv[i].st});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_err_pulse", i), {31'd0, cmd_err}, 32'd0);
        end
    endtask

    task automatic load_prog(input logic [31:0] arg, input int n);
        do_cmd(LD, arg);
        chk("ld_state", {29'd0, state}, {29'd0, S_LOAD});
        chk("ld_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        ld_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            ld_data = wbuf[i];
            #1;
            chk("ld_we", {31'd0, imem_we}, 32'd1);
            chk("ld_addr", {22'd0, imem_addr}, 32'(i));
            chk("ld_wdata", imem_wdata, wbuf[i]);
            chk("ld_core_rst", {31'd0, core_reset_n}, 32'd0);
            @(posedge clk); #1;
        end
        for (int c = 0; c < 2; c++) begin
            chk("prime_state", {29'd0, state}, {29'd0, S_PRIME});
            chk("prime_core_rst", {31'd0, core_reset_n}, 32'd0);
            chk("prime_no_we", {31'd0, imem_we}, 32'd0);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        chk("load_done_state", {29'd0, state}, {29'd0, S_IDLE});
        chk("load_done_rst", {31'd0, core_reset_n}, 32'd1);
        chk("load_done_cc", cycle_count, 32'd0);
        for (int i = 0; i < n; i++) m_mem[i] = wbuf[i];
        m_pc = 0; m_cc = 0; m_loaded = 1'b1; m_trapped = 1'b0; m_st = S_IDLE;
    endtask

    // model: program runs straight through memory; stop at first trap or when the budget is spent
    task automatic run_cmd(input logic [1:0] op, input int unsigned arg);
        int unsigned k, j, en, cyc;
        logic tr;
        if (!m_loaded || m_trapped) begin
            do_cmd(op, arg);
            chk("illegal_err", {31'd0, cmd_err}, 32'd1);
            chk("illegal_state", {29'd0, state}, {29'd0, m_st});
            return;
        end
        k = arg == 0 ? 4000 : arg;
        j = 0;
        while (j < k && !is_trap(m_mem[(m_pc + j) % 1024])) j++;
        tr = j < k;
        do_cmd(op, arg);
        chk("legal_no_err", {31'd0, cmd_err}, 32'd0);
        en = 0; cyc = 0;
        while (state == S_RUN && cyc < k + 4) begin
            if (core_en) en++;
            cyc++;
            @(posedge clk); #1;
        end
        chk("run_halted", {29'd0, state}, {29'd0, S_HALT});
        chk("run_en_cycles", en, j);
        chk("run_cycles", cyc, tr ? j + 1 : j);
        chk("run_cause", {30'd0, halt_cause}, tr ? 32'd1 : op == ST ? 32'd3 : 32'd2);
        chk("run_halted_pc", halted_pc, tr ? (m_pc + j) * 4 : (m_pc + j - 1) * 4);
        m_cc += j;
        m_pc += j;
        chk("run_cycle_count", cycle_count, m_cc);
        m_trapped = tr;
        m_st = S_HALT;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{RN, 32'd5, 1'b1, S_IDLE};
        tv[1] = '{ST, 32'd0, 1'b1, S_IDLE};
        tv[2] = '{LD, 32'd0, 1'b1, S_IDLE};
        tv[3] = '{HT, 32'd0, 1'b0, S_IDLE};
        tv[4] = '{ST, 32'd3, 1'b1, S_IDLE};
        tv[5] = '{RN, 32'd0, 1'b1, S_IDLE};
        tv[6] = '{RN, 32'd0, 1'b1, S_HALT};
        tv[7] = '{ST, 32'd2, 1'b1, S_HALT};
        tv[8] = '{HT, 32'd0, 1'b0, S_HALT};
        tv[9] = '{LD, 32'd0, 1'b1, S_HALT};
        for (int i = 0; i < 1024; i++) m_mem[i] = NOP;
        m_pc = 0; m_cc = 0; m_loaded = 1'b0; m_trapped = 1'b0; m_st = S_IDLE;

        #12;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_core_rst", {31'd0, core_reset_n}, 32'd0);
        chk("rst_core_en", {31'd0, core_en}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_err", {31'd0, cmd_err}, 32'd0);
        chk("rst_cause", {30'd0, halt_cause}, 32'd0);
        chk("rst_hpc", halted_pc, 32'd0);
        chk("rst_cc", cycle_count, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        apply_vecs(0, 5);

        wbuf[0] = 32'h0000_0013; wbuf[1] = 32'h0010_0093; wbuf[2] = 32'h0020_0113;
        load_prog(32'd3, 3);
        run_cmd(ST, 5);

        for (int i = 0; i < 4; i++) wbuf[i] = NOP;
        wbuf[4] = EBREAK;
        load_prog(32'd5, 5);
        run_cmd(RN, 0);
        apply_vecs(6, 9);

        // budget expiry and HALT land in the same cycle
        for (int i = 0; i < 12; i++) wbuf[i] = NOP;
        load_prog(32'd12, 12);
        do_cmd(RN, 32'd10);
        repeat (9) begin @(posedge clk); #1; end
        chk("lim_still_run", {29'd0, state}, {29'd0, S_RUN});
        do_cmd(HT, 32'd0);
        chk("lim_state", {29'd0, state}, {29'd0, S_HALT});
        chk("lim_cause", {30'd0, halt_cause}, 32'd2);
        chk("lim_cc", cycle_count, 32'd10);
        chk("lim_hpc", halted_pc, 32'd36);
        m_pc = 10; m_cc = 10; m_st = S_HALT;

        // user halt, with an illegal LOAD in between
        do_cmd(RN, 32'd0);
        do_cmd(LD, 32'd4);
        chk("run_load_err", {31'd0, cmd_err}, 32'd1);
        chk("run_load_state", {29'd0, state}, {29'd0, S_RUN});
        do_cmd(HT, 32'd0);
        chk("user_state", {29'd0, state}, {29'd0, S_HALT});
        chk("user_cause", {30'd0, halt_cause}, 32'd0);
        chk("user_cc", cycle_count, 32'd12);
        chk("user_hpc", halted_pc, 32'd44);
        chk("user_no_en", {31'd0, core_en}, 32'd0);

        for (int r = 0; r < 15; r++) begin
            int n;
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) wbuf[i] = rword();
            load_prog(32'(n), n);
            repeat ($urandom_range(1, 4)) run_cmd($urandom_range(0, 1) != 0 ? ST : RN, $urandom_range(1, 8));
        end

        // oversized load is clamped to the memory depth
        for (int i = 0; i < 1024; i++) wbuf[i] = rword();
        load_prog(32'd2000, 1024);
        run_cmd(ST, 3);

        // reset mid-load
        do_cmd(LD, 32'd8);
        ld_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ld_data = 32'(i);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        chk("mid_rst_state", {29'd0, state}, 32'd0);
        chk("mid_rst_core_rst", {31'd0, core_reset_n}, 32'd0);
        chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
        ld_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_loaded = 1'b0; m_trapped = 1'b0; m_st = S_IDLE;
        @(posedge clk); #1;
        run_cmd(RN, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Run controller for the single-cycle RV32I core. It streams a program into instruction memory and holds the core in reset while loading. It then gates core execution (run, step, halt) through a per-cycle enable and stops the core on ECALL/EBREAK or a cycle limit. It sits between a host/debug command port and the core's `clk`-domain control inputs (PC/register-file/data-memory write enables, core reset).

## Interface
Parameters:
- `DEPTH` — 1024 — instruction memory depth in words.
- `ADDR_W` — 10 — word-address width, `$clog2(DEPTH)`.
- `RST_CYCLES` — 2 — cycles the core reset is held after a load completes (≥1).

Ports:
- `clk` — in — 1 — single clock, rising edge.
- `reset` — in — 1 — asynchronous, active-low reset.
- `cmd_valid` — in — 1 — command request.
- `cmd_ready` — out — 1 — command accepted when both valid and ready are high.
- `cmd_op` — in — 2 — 0 LOAD, 1 RUN, 2 STEP, 3 HALT.
- `cmd_arg` — in — 32 — LOAD: word count; RUN: cycle limit (0 = unlimited); STEP: cycle count.
- `cmd_err` — out — 1 — one-cycle pulse when an accepted command is illegal.
- `ld_valid` — in — 1 — program word valid.
- `ld_ready` — out — 1 — sequencer accepts a program word.
- `ld_data` — in — 32 — program word.
- `imem_we` — out — 1 — instruction memory write strobe.
- `imem_addr` — out — ADDR_W — word address of the write.
- `imem_wdata` — out — 32 — write data.
- `core_reset_n` — out — 1 — core reset, active-low.
- `core_en` — out — 1 — core commit enable (PC update, register-file write, data-memory write).
- `core_instr` — in — 32 — instruction currently fetched by the core.
- `core_pc` — in — 32 — current PC of the core.
- `state` — out — 3 — 0 IDLE, 1 LOAD, 2 PRIME, 3 RUN, 4 HALTED.
- `halt_cause` — out — 2 — 0 USER, 1 TRAP, 2 LIMIT, 3 STEP.
- `halted_pc` — out — 32 — `core_pc` captured on entry to HALTED.
- `cycle_count` — out — 32 — enabled cycles since the last LOAD completed.

## Operation
- **Reset values.**
  - `state`=IDLE; `core_reset_n`=0; `core_en`=0.
  - `imem_we`=0; `cmd_err`=0.
  - `halt_cause`=0; `halted_pc`=0; `cycle_count`=0.
  - Internal `loaded`=0; `trapped`=0.
- **cmd_ready.** High in IDLE, RUN and HALTED. Low in LOAD and PRIME.
- **IDLE / HALTED accepting LOAD(N).**
  - N=0 is illegal: pulse `cmd_err`, state unchanged.
  - N>DEPTH is clamped to DEPTH.
  - Otherwise: load counter ← 0, `loaded`←0, `trapped`←0, go to LOAD.
- **LOAD.**
  - `core_reset_n`=0; `ld_ready`=1.
  - `imem_we` = `ld_valid & ld_ready` (combinational). `imem_addr` = counter; `imem_wdata` = `ld_data`.
  - The counter increments on each handshake.
  - After the Nth handshake, go to PRIME.
- **PRIME.**
  - `core_reset_n`=0 for exactly RST_CYCLES cycles.
  - Then go to IDLE with `loaded`←1, `cycle_count`←0, and `core_reset_n`←1 from then on.
- **RUN(L) / STEP(K) accepted in IDLE or HALTED.**
  - Illegal (pulse `cmd_err`) if `loaded`=0, or `trapped`=1, or the op is STEP with K=0.
  - Otherwise: budget ← L or K, unlimited ← (RUN and L=0), go to RUN.
- **HALT accepted in IDLE / HALTED.** No-op, no error.
- **LOAD accepted in RUN.** Illegal (pulse `cmd_err`).
- **RUN state.**
  - `trap` = (`core_instr`==32'h00000073 or 32'h00100073).
  - `core_en` = !`trap` (combinational), so the trapping instruction never commits.
  - Each cycle with `core_en`=1: `cycle_count`+1 (wraps at 2^32); budget−1 unless unlimited.
- **RUN exit conditions** (priority in this order when several occur in the same cycle):
  - `trap` → HALTED, cause TRAP, `trapped`←1.
  - budget reaches 0 on this cycle → HALTED, cause LIMIT for RUN, STEP for STEP.
  - HALT command accepted → HALTED, cause USER. This cycle still commits.
- **halted_pc.** Captured from `core_pc` in the cycle HALTED is entered. For TRAP this is the trap instruction's address.

## Timing
- All state and counters register on the rising edge of `clk`.
- `reset` low clears everything immediately, including mid-LOAD. A partial load leaves `loaded`=0.
- LOAD of N words with `ld_valid` held high: N cycles of writes, then RST_CYCLES cycles in PRIME, then IDLE on cycle N+RST_CYCLES+1.
- STEP(K) with no trap: exactly K cycles with `core_en`=1; HALTED is visible the cycle after the Kth.
- Command to effect: a command accepted at edge t changes `state` at edge t; `core_en` first rises in the cycle after acceptance.
- `cmd_err` is high for the single cycle after the illegal command's acceptance edge.
- `imem_we` is never high outside LOAD. `core_en` is never high outside RUN.

## Test plan
- **Reset and first load.** Reset, then LOAD(3) with words A,B,C back-to-back. Expect:
  - `imem_we` high for 3 cycles at addresses 0,1,2.
  - `core_reset_n`=0 until 2 cycles after the last write.
  - `state`=IDLE and `cycle_count`=0.
- **Step.** STEP(5) on a NOP program. Expect `core_en` high for exactly 5 cycles, HALTED, `halt_cause`=3, `cycle_count`=5.
- **Trap.** Program with EBREAK at word 4, then RUN(0). Expect HALTED, `halt_cause`=1, `halted_pc`=0x10, `cycle_count`=4, `core_en`=0 in the EBREAK cycle. A subsequent RUN produces a `cmd_err` pulse.
- **Limit vs halt.** RUN(10) with HALT issued in the same cycle the budget expires. Expect `halt_cause`=2 (LIMIT wins) and `cycle_count`=10.
- **Illegal commands.** RUN before any LOAD, LOAD(0), and LOAD during RUN. Each gives a one-cycle `cmd_err` with `state` unchanged.
- **Reset mid-operation.** Assert `reset` low mid-LOAD after 2 of 8 words. Expect immediate IDLE with `core_reset_n`=0; a following RUN gives `cmd_err`.
